// File: rtl/sobel_edge_det_param.sv
// rtl/sobel_edge_det_param.sv - parametrised streaming 3x3 Sobel edge detector
//
// Purpose: converts an RGB pixel stream to luma, buffers two lines, and emits a
// saturated, thresholded gradient magnitude with a fixed 3-cycle latency.
// Ports:
//   clk, rst_n              pixel clock, synchronous active-low reset
//   in_valid/in_sof/in_sol  pixel qualifier, first pixel of frame / of line
//   in_rgb                  {R,G,B} input pixel
//   gray_bypass             1: luma = G channel, 0: weighted conversion
//   mode                    0: |gx|+|gy|, 1: |gx|, 2: |gy|, 3: max(|gx|,|gy|)
//   thresh_wr/thresh_in     threshold register load
//   out_valid/out_mag/out_edge/out_rgb  result stream (out_rgb = window centre)
//   overflow                sticky: a line exceeded LINE_W pixels
module sobel_edge_det_param #(
  parameter int DATA_W     = 8,
  parameter int LINE_W     = 640,
  parameter int ADDR_W     = 10,
  parameter int THRESH_RST = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_sol,
  input  logic [3*DATA_W-1:0]   in_rgb,
  input  logic                  gray_bypass,
  input  logic [1:0]            mode,
  input  logic                  thresh_wr,
  input  logic [DATA_W-1:0]     thresh_in,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_mag,
  output logic                  out_edge,
  output logic [3*DATA_W-1:0]   out_rgb,
  output logic                  overflow
);

  localparam int MW    = DATA_W + 3;  // signed gradient / mode result width
  localparam int AW    = DATA_W + 2;  // absolute gradient width
  localparam int LW    = DATA_W + 8;  // luma accumulator width
  localparam int ROW_W = 8;
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_W - 1);

  logic                started;
  logic [ADDR_W-1:0]   col, col_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [DATA_W-1:0]   thresh;

  logic                sol, accept, at_end, wr_en, ovf_hit;
  logic [DATA_W-1:0]   r_ch, g_ch, b_ch, luma;
  logic [LW-1:0]       luma_acc;

  logic [DATA_W-1:0]   lb0 [0:LINE_W-1];     // previous line luma
  logic [DATA_W-1:0]   lb1 [0:LINE_W-1];     // line before that
  logic [3*DATA_W-1:0] rgb_lb [0:LINE_W-1];  // previous line RGB, for centre pass-through

  logic [DATA_W-1:0]   p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [3*DATA_W-1:0] rgb_right, rgb_mid;
  logic                s1_valid, s1_mask;

  logic signed [MW-1:0] gx, gy;
  logic [AW-1:0]       s2_ax, s2_ay;
  logic                s2_valid, s2_mask;
  logic [3*DATA_W-1:0] s2_rgb;

  logic [MW-1:0]       m3;
  logic [DATA_W-1:0]   sat3, mag3;

  // in_sof implies in_sol; pixels before the first in_sof are dropped.
  assign sol     = in_sol | in_sof;
  assign accept  = in_valid & (in_sof | started);
  assign at_end  = (col == COL_LAST);
  assign ovf_hit = accept & ~sol & at_end;

  always_comb begin
    col_nxt = col;
    row_nxt = row;
    wr_en   = 1'b1;
    if (sol) begin
      col_nxt = '0;
      if (in_sof)
        row_nxt = '0;
      else if (row != '1)
        row_nxt = row + ROW_W'(1);
    end else if (at_end) begin
      wr_en = 1'b0;  // over-long line: hold at the last column, keep the buffers intact
    end else begin
      col_nxt = col + ADDR_W'(1);
    end
  end

  assign r_ch     = in_rgb[3*DATA_W-1 -: DATA_W];
  assign g_ch     = in_rgb[2*DATA_W-1 -: DATA_W];
  assign b_ch     = in_rgb[DATA_W-1:0];
  assign luma_acc = LW'(54) * LW'(r_ch) + LW'(183) * LW'(g_ch) + LW'(18) * LW'(b_ch);
  assign luma     = gray_bypass ? g_ch : DATA_W'(luma_acc >> 8);

  // Control, valid pipe and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started   <= 1'b0;
      col       <= '0;
      row       <= '0;
      overflow  <= 1'b0;
      thresh    <= DATA_W'(THRESH_RST);
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_edge  <= 1'b0;
      out_rgb   <= '0;
    end else begin
      if (thresh_wr)
        thresh <= thresh_in;
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_mag   <= mag3;
      out_edge  <= (mag3 != '0);
      out_rgb   <= s2_rgb;
      if (accept) begin
        started <= 1'b1;
        col     <= col_nxt;
        row     <= row_nxt;
        if (ovf_hit)
          overflow <= 1'b1;
      end
    end
  end

  // Stage 1: line buffers and window. The new right-hand column is
  // {row-2, row-1, row} at col, so the centre sits at (row-1, col-1).
  // Reads return the value before this cycle's write, i.e. the older line.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr_en) begin
        lb0[col_nxt]    <= luma;
        lb1[col_nxt]    <= lb0[col_nxt];
        rgb_lb[col_nxt] <= in_rgb;
      end
      p0 <= p1;  p1 <= p2;  p2 <= lb1[col_nxt];
      p3 <= p4;  p4 <= p5;  p5 <= lb0[col_nxt];
      p6 <= p7;  p7 <= p8;  p8 <= luma;
      rgb_right <= rgb_lb[col_nxt];
      rgb_mid   <= rgb_right;
      s1_mask   <= (row_nxt < ROW_W'(2)) | (col_nxt < ADDR_W'(2));
    end
  end

  function automatic logic signed [MW-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  // Stage 2: gradients and absolute values.
  assign gx = (ext(p2) - ext(p0)) + ((ext(p5) - ext(p3)) <<< 1) + (ext(p8) - ext(p6));
  assign gy = (ext(p0) - ext(p6)) + ((ext(p1) - ext(p7)) <<< 1) + (ext(p2) - ext(p8));

  always_ff @(posedge clk) begin
    s2_ax   <= AW'(gx[MW-1] ? -gx : gx);
    s2_ay   <= AW'(gy[MW-1] ? -gy : gy);
    s2_mask <= s1_mask;
    s2_rgb  <= rgb_mid;
  end

  // Stage 3: mode select, saturate, threshold, border mask.
  always_comb begin
    unique case (mode)
      2'd0:    m3 = MW'(s2_ax) + MW'(s2_ay);
      2'd1:    m3 = MW'(s2_ax);
      2'd2:    m3 = MW'(s2_ay);
      default: m3 = (s2_ax > s2_ay) ? MW'(s2_ax) : MW'(s2_ay);
    endcase
    sat3 = (m3 > MW'((2 ** DATA_W) - 1)) ? '1 : m3[DATA_W-1:0];
    mag3 = (s2_mask || (sat3 <= thresh)) ? '0 : sat3;
  end

endmodule

// File: tb/tb_sobel_edge_det_param.sv
// tb/tb_sobel_edge_det_param.sv - self-checking bench for sobel_edge_det_param
module tb_sobel_edge_det_param;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int AW = 3;
  localparam int TR = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_sof, in_sol, gray_bypass, thresh_wr;
  logic [23:0]   in_rgb;
  logic [1:0]    mode;
  logic [7:0]    thresh_in;
  logic          out_valid, out_edge, overflow;
  logic [7:0]    out_mag;
  logic [23:0]   out_rgb;

  sobel_edge_det_param #(.DATA_W(DW), .LINE_W(LW), .ADDR_W(AW), .THRESH_RST(TR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_sol(in_sol),
    .in_rgb(in_rgb), .gray_bypass(gray_bypass), .mode(mode), .thresh_wr(thresh_wr),
    .thresh_in(thresh_in), .out_valid(out_valid), .out_mag(out_mag), .out_edge(out_edge),
    .out_rgb(out_rgb), .overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          mag;
    logic [23:0] rgb;
    int          stamp;
    int          r;
    int          c;
    bit          masked;
    bit          dc;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  int          img    [0:15][0:15];
  logic [23:0] rgbimg [0:15][0:15];
  int          got_mag[0:15][0:15];
  int          nvalid;
  bit          m_started;
  int          m_row, m_col, m_thresh, m_mode;
  bit          m_byp;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: 3x3 window of the current frame, rows r-2..r, cols c-2..c.
  function automatic int model_mag(input int r, input int c);
    int gx, gy, ax, ay, v;
    if (r < 2 || c < 2) return 0;
    gx = 0; gy = 0;
    for (int k = 0; k < 3; k++) begin
      int wt;
      wt = (k == 1) ? 2 : 1;
      gx += wt * (img[r-2+k][c] - img[r-2+k][c-2]);
      gy += wt * (img[r-2][c-2+k] - img[r][c-2+k]);
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m_mode)
      0: v = ax + ay;
      1: v = ax;
      2: v = ay;
      default: v = (ax > ay) ? ax : ay;
    endcase
    if (v > 255) v = 255;
    return (v <= m_thresh) ? 0 : v;
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        ce = q.pop_front();
        check("latency", cyc - ce.stamp, 3);
        if (!ce.dc) begin
          check("mag", int'(out_mag), ce.mag);
          check("edge", int'(out_edge), int'(ce.mag != 0));
          if (!ce.masked) check("rgb", int'(out_rgb), int'(ce.rgb));
        end
        got_mag[ce.r][ce.c] = int'(out_mag);
        nvalid++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic send(input logic [23:0] rgb, input bit sol, input bit sof,
                      input bit gaps, input bit dc);
    int   y;
    bit   wr;
    exp_t e;
    if (gaps && $urandom_range(0, 1) == 1) idle(1);
    @(negedge clk);
    in_valid = 1'b1; in_rgb = rgb; in_sol = sol; in_sof = sof;
    if (!sof && !m_started) return;
    y  = m_byp ? int'(rgb[15:8]) : (54 * rgb[23:16] + 183 * rgb[15:8] + 18 * rgb[7:0]) >> 8;
    wr = 1'b1;
    if (sof) begin
      m_started = 1'b1; m_row = 0; m_col = 0;
    end else if (sol) begin
      m_col = 0;
      if (m_row < 255) m_row++;
    end else if (m_col == LW - 1) begin
      wr = 1'b0;
    end else begin
      m_col++;
    end
    if (wr) begin
      img[m_row][m_col]    = y;
      rgbimg[m_row][m_col] = rgb;
    end
    e.r      = m_row;
    e.c      = m_col;
    e.masked = (m_row < 2 || m_col < 2);
    e.mag    = model_mag(m_row, m_col);
    e.rgb    = (m_row >= 1 && m_col >= 1) ? rgbimg[m_row-1][m_col-1] : 24'h0;
    e.stamp  = cyc;
    e.dc     = dc;
    q.push_back(e);
  endtask

  function automatic logic [23:0] pix(input int kind, input int r, input int c);
    logic [7:0] g;
    case (kind)
      0: g = 8'd100;
      1: g = (c < 4) ? 8'd0 : 8'd255;
      2: g = 8'(2 * c);
      3: g = (r == 2 && c == 2) ? 8'd200 : 8'd0;
      default: return 24'($urandom);
    endcase
    return {8'($urandom), g, 8'($urandom)};
  endfunction

  task automatic cfg(input int md, input bit byp);
    @(negedge clk);
    in_valid = 1'b0;
    mode = 2'(md); gray_bypass = byp;
    m_mode = md; m_byp = byp;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) got_mag[r][c] = -1;
    nvalid = 0;
  endtask

  task automatic run_frame(input int kind, input int rows, input int len0, input int md,
                           input bit byp, input bit gaps, input bit dc);
    cfg(md, byp);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < ((r == 0) ? len0 : LW); c++)
        send(pix(kind, r, c), c == 0, r == 0 && c == 0, gaps, dc);
    idle(6);
    check("queue_drained", q.size(), 0);
  endtask

  function automatic int nonzero(input int r_lo, input int r_hi);
    int n = 0;
    for (int r = r_lo; r <= r_hi; r++)
      for (int c = 0; c < LW; c++) if (got_mag[r][c] > 0) n++;
    return n;
  endfunction

  task automatic write_thresh(input int t);
    @(negedge clk);
    in_valid = 1'b0; thresh_wr = 1'b1; thresh_in = 8'(t);
    @(negedge clk);
    thresh_wr = 1'b0;
    m_thresh = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    m_started = 1'b0; m_row = 0; m_col = 0; m_thresh = TR;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_mag", int'(out_mag), 0);
    check("rst_out_edge", int'(out_edge), 0);
    check("rst_out_rgb", int'(out_rgb), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
  endtask

  int diag_exp[4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sol = 1'b0; in_rgb = '0;
    gray_bypass = 1'b1; mode = 2'd0; thresh_wr = 1'b0; thresh_in = '0;
    m_started = 1'b0; m_row = 0; m_col = 0; m_thresh = TR; m_mode = 0; m_byp = 1'b1;
    nvalid = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin img[r][c] = 0; rgbimg[r][c] = '0; end
    repeat (3) @(posedge clk);
    do_reset();

    // Pixels before the first in_sof must be ignored.
    nvalid = 0;
    send(24'h102030, 1'b1, 1'b0, 1'b0, 1'b0);
    send(24'h405060, 1'b0, 1'b0, 1'b0, 1'b0);
    send(24'h708090, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("pre_sof_valids", nvalid, 0);

    // Flat frame.
    run_frame(0, 4, LW, 0, 1'b1, 1'b0, 1'b0);
    check("flat_count", nvalid, 32);
    check("flat_nonzero", nonzero(0, 3), 0);

    // Vertical step, modes 0 and 2.
    run_frame(1, 4, LW, 0, 1'b1, 1'b0, 1'b0);
    check("step_m0_nonzero", nonzero(0, 3), 4);
    check("step_m0_r2c4", got_mag[2][4], 255);
    check("step_m0_r3c5", got_mag[3][5], 255);
    check("step_m0_r2c6", got_mag[2][6], 0);
    run_frame(1, 4, LW, 2, 1'b1, 1'b0, 1'b0);
    check("step_m2_nonzero", nonzero(0, 3), 0);

    // Horizontal ramp against the threshold.
    run_frame(2, 4, LW, 1, 1'b1, 1'b0, 1'b0);
    check("ramp_t19_nonzero", nonzero(0, 3), 0);
    write_thresh(15);
    run_frame(2, 4, LW, 1, 1'b1, 1'b0, 1'b0);
    check("ramp_t15_nonzero", nonzero(0, 3), 12);
    check("ramp_t15_r3c5", got_mag[3][5], 16);

    // Single bright pixel, all four modes.
    diag_exp = '{255, 200, 200, 200};
    for (int md = 0; md < 4; md++) begin
      run_frame(3, 5, LW, md, 1'b1, 1'b0, 1'b0);
      check("diag_r4c4", got_mag[4][4], diag_exp[md]);
    end

    // Weighted luma, continuous and with gaps.
    run_frame(4, 4, LW, 0, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, LW, 3, 1'b0, 1'b0, 1'b0);
    run_frame(4, 4, LW, 0, 1'b0, 1'b1, 1'b0);
    check("gap_count", nvalid, 32);

    // Mid-frame reset at row 2.
    cfg(0, 1'b0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 4 : LW); c++)
        send(pix(4, r, c), c == 0, r == 0 && c == 0, 1'b0, 1'b0);
    do_reset();
    nvalid = 0;
    for (int c = 0; c < 4; c++) send(pix(4, 3, c), c == 0, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("post_rst_no_sof", nvalid, 0);
    run_frame(4, 4, LW, 0, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", nvalid, 32);
    check("post_rst_rows01", nonzero(0, 1), 0);

    // Over-long line sets the sticky overflow flag.
    check("ovf_before", int'(overflow), 0);
    run_frame(4, 2, 10, 0, 1'b0, 1'b0, 1'b1);
    check("ovf_count", nvalid, 18);
    check("ovf_set", int'(overflow), 1);
    run_frame(4, 4, LW, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_sticky", int'(overflow), 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_edge_det_param.md
Name: sobel_edge_det_param

Overview:
- Parametrised streaming 3x3 Sobel edge detector; successor to the fixed 640-wide, 8-bit, always-|gx|+|gy| detector.
- Sits in the video pipeline between the D8M capture/RGB stage and the display mux.
- Accepts one RGB pixel per valid cycle and converts it to luma (or bypasses the conversion).
- Buffers two lines, then emits a saturated, thresholded gradient magnitude with valid tracking, border masking, a selectable gradient mode and a line-overflow flag.

Parameters:
- DATA_W, 8: bits per colour channel and per magnitude output.
- LINE_W, 640: maximum pixels per line; line-buffer depth.
- ADDR_W, 10: line-buffer address width; must satisfy 2^ADDR_W >= LINE_W.
- THRESH_RST, 19: threshold value loaded at reset.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid  in  1  pixel qualifier; the pipeline advances only when this is high.
- in_sof  in  1  first pixel of frame; qualified by in_valid; implies in_sol.
- in_sol  in  1  first pixel of line; qualified by in_valid.
- in_rgb  in  3*DATA_W  {R,G,B} pixel.
- gray_bypass  in  1  1: luma = G channel; 0: weighted conversion.
- mode  in  2  0: |gx|+|gy|; 1: |gx|; 2: |gy|; 3: max(|gx|,|gy|).
- thresh_wr  in  1  load thresh_in into the threshold register.
- thresh_in  in  DATA_W  new threshold.
- out_valid  out  1  out_mag/out_edge/out_rgb valid.
- out_mag  out  DATA_W  thresholded magnitude.
- out_edge  out  1  out_mag != 0.
- out_rgb  out  3*DATA_W  window-centre pixel, delayed in step with out_mag (cartoon pass-through).
- overflow  out  1  sticky flag: a line exceeded LINE_W pixels.

Behaviour:
- Reset:
  - Registered outputs go to 0: out_valid, out_mag, out_edge, out_rgb, overflow.
  - Row counter = 0, column counter = 0, valid pipe cleared, threshold = THRESH_RST.
  - Line-buffer RAM is not cleared; border masking hides stale data.
  - A reset mid-frame discards the frame. Output restarts only after the next in_sof.
  - Pixels arriving before the first in_sof after reset are ignored: they produce no out_valid and no writes.
- Luma:
  - gray_bypass=0: Y = (54*R + 183*G + 18*B) >> 8, truncated, DATA_W bits.
  - gray_bypass=1: Y = G.
- Counters (advance on in_valid only):
  - in_sol sets col = 0; in_sof additionally sets row = 0.
  - Otherwise col increments.
  - When col reaches LINE_W-1 and a further non-sol pixel arrives: col holds at LINE_W-1, line-buffer writes are suppressed, and overflow sets. overflow clears only on reset.
  - Row increments on each in_sol that is not in_sof, saturating at its maximum count.
- Window:
  - Two line buffers of LINE_W x DATA_W luma, plus a three-row x three-column window register.
  - These buffers and the window shift only on in_valid.
  - The window for the input pixel at (row,col) is centred at (row-1,col-1).
- Border masking: if row<2 or col<2, the magnitude is forced to 0 and out_valid still asserts, so the output pixel count equals the input pixel count. The last column and last row are never window centres.
- Arithmetic:
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6); gy = (p0-p6) + 2(p1-p7) + (p2-p8).
  - Both are signed, DATA_W+3 bits; absolute values are DATA_W+2 bits unsigned.
  - The mode result (DATA_W+3 bits) saturates to 2^DATA_W-1.
  - If the saturated value <= threshold, out_mag = 0; else out_mag = the saturated value.
- Latency: out_valid = in_valid delayed exactly 3 clk cycles, fixed and independent of gaps. Stage 1: luma + buffer/window. Stage 2: gx/gy/abs. Stage 3: mode, saturate, threshold, output register.
- Config timing: mode, gray_bypass and the threshold are sampled at the stage that uses them; changes take effect on the next cycle with no glitch requirement.
- Threshold register: updates on thresh_wr in any cycle. It takes effect for pixels reaching stage 3 on the next cycle.
- in_valid low: no counter, buffer or window change; out_valid drops 3 cycles later.

Test Plan:
- Flat frame: LINE_W=8, gray_bypass=1, 4 lines of G=100 -> out_mag=0 for all 32 outputs; exactly 32 out_valid pulses; first pulse 3 cycles after first in_valid.
- Vertical step: LINE_W=8, gray_bypass=1, cols 0-3 G=0, cols 4-7 G=255, 4 lines, mode 0 -> rows 2-3, cols 4 and 5 give out_mag=255 (gx=1020 saturated). All other cols give 0. Mode 2 gives 0 everywhere.
- Threshold: horizontal ramp G=2*col, mode 1 -> gx=16, out_mag=0 with reset threshold 19. After thresh_wr with thresh_in=15, out_mag=16 for the interior pixels.
- Mode 3 on a diagonal: pixel (2,2)=200, all others 0 -> at an interior centre adjacent to it, out_mag equals max(|gx|,|gy|) per the formula, checked against a reference model for all 4 modes.
- Gaps and overflow: random in_valid duty of 50% gives the same out_mag sequence as continuous input. A 10-pixel line with LINE_W=8 sets overflow=1; it stays set until rst_n=0.
- Mid-frame reset: rst_n low for 1 cycle at row 2 -> all outputs 0 the next cycle; no out_valid until the next in_sof; the next frame's first two rows give out_mag=0.
